// File: rtl/qspi_rx_packer_if.sv
// Packer control/data bundle: QSPI FSM and pad side in, RX FIFO write port and status out.
interface qspi_rx_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  byte_count;
  logic [1:0]            lane_mode;
  logic                  sample_en;
  logic [3:0]            io_in;
  logic                  rx_full;
  logic                  rx_wen;
  logic [DATA_WIDTH-1:0] rx_data_fifo;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  bytes_rcvd;
  logic                  drop_err;

  modport master (
    output start, abort, byte_count, lane_mode, sample_en, io_in, rx_full,
    input  rx_wen, rx_data_fifo, busy, done, bytes_rcvd, drop_err
  );

  modport slave (
    input  start, abort, byte_count, lane_mode, sample_en, io_in, rx_full,
    output rx_wen, rx_data_fifo, busy, done, bytes_rcvd, drop_err
  );
endinterface

// File: rtl/qspi_rx_packer.sv
// QSPI RX deserializer: 1/2/4-bit sampling into MSB-first bytes, packed
// little-endian into 32-bit words written to the RX FIFO.
module qspi_rx_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          rst,
  qspi_rx_packer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [1:0]           mode;
  logic [CNT_WIDTH-1:0] bytes_left;
  logic [3:0]           bit_cnt;
  logic [7:0]           byte_sr;
  logic [1:0]           byte_idx;
  logic [3:0][7:0]      word;

  logic [3:0]      step;
  logic [3:0]      bit_nxt;
  logic [7:0]      sr_nxt;
  logic            byte_done;
  logic            last_byte;
  logic            issue;
  logic [3:0][7:0] word_nxt;

  always_comb begin
    // mode 11 is reserved and behaves as single
    step   = 4'd1;
    sr_nxt = {byte_sr[6:0], bus.io_in[1]};
    case (mode)
      2'b01: begin step = 4'd2; sr_nxt = {byte_sr[5:0], bus.io_in[1:0]}; end
      2'b10: begin step = 4'd4; sr_nxt = {byte_sr[3:0], bus.io_in[3:0]}; end
      default: ;
    endcase
    bit_nxt   = bit_cnt + step;
    byte_done = (state == SHIFT) && bus.sample_en && !bus.abort && (bit_nxt == 4'd8);
    last_byte = (bytes_left == CNT_WIDTH'(1));
    issue     = byte_done && ((byte_idx == 2'd3) || last_byte);
    word_nxt           = word;
    word_nxt[byte_idx] = sr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mode             <= '0;
      bytes_left       <= '0;
      bit_cnt          <= '0;
      byte_sr          <= '0;
      byte_idx         <= '0;
      word             <= '0;
      bus.rx_wen       <= 1'b0;
      bus.rx_data_fifo <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.bytes_rcvd   <= '0;
      bus.drop_err     <= 1'b0;
    end else begin
      bus.rx_wen <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          mode           <= bus.lane_mode;
          bytes_left     <= bus.byte_count;
          bit_cnt        <= '0;
          byte_sr        <= '0;
          byte_idx       <= '0;
          word           <= '0;
          bus.bytes_rcvd <= '0;
          bus.drop_err   <= 1'b0;
          if (bus.byte_count == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state    <= SHIFT;
            bus.busy <= 1'b1;
          end
        end
        SHIFT: if (bus.abort) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end else if (bus.sample_en) begin
          byte_sr <= sr_nxt;
          bit_cnt <= byte_done ? 4'd0 : bit_nxt;
          if (byte_done) begin
            bus.bytes_rcvd <= bus.bytes_rcvd + 1'b1;
            bytes_left     <= bytes_left - 1'b1;
            byte_idx       <= byte_idx + 1'b1;
            word           <= issue ? '0 : word_nxt;
            if (issue) begin
              bus.rx_wen       <= 1'b1;
              bus.rx_data_fifo <= DATA_WIDTH'(word_nxt);
              if (bus.rx_full) bus.drop_err <= 1'b1;
            end
            if (last_byte) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_rx_packer.sv
// Bench for qspi_rx_packer: transaction-level bit/byte model checked every cycle,
// directed scenarios with literal word expectations, then randomized transfers.
module tb_qspi_rx_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_rx_packer_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  qspi_rx_packer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  // reference model: bits collected per transfer, bytes appended as they complete
  logic        m_act = 1'b0, m_dn = 1'b0;
  int          m_n, m_cnt, m_bits;
  logic [7:0]  m_cur;
  logic [7:0]  m_bytes[$];
  logic        exp_wen, exp_done, exp_drop;
  logic [31:0] exp_data;
  int          exp_rcvd;

  always @(posedge clk) begin
    exp_wen  = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      m_act = 0; m_dn = 0; exp_data = '0; exp_drop = 0; exp_rcvd = 0;
      m_bits = 0; m_bytes.delete();
    end else if (m_dn) begin
      m_dn = 0;
    end else if (!m_act) begin
      if (bus.start) begin
        exp_drop = 0; exp_rcvd = 0; m_bits = 0; m_cur = '0; m_bytes.delete();
        m_cnt = int'(bus.byte_count);
        m_n   = (bus.lane_mode == 2'b01) ? 2 : (bus.lane_mode == 2'b10) ? 4 : 1;
        if (m_cnt == 0) begin m_dn = 1; exp_done = 1; end
        else m_act = 1;
      end
    end else if (bus.abort) begin
      m_act = 0;
    end else if (bus.sample_en) begin
      for (int i = m_n - 1; i >= 0; i--) begin
        m_cur = {m_cur[6:0], (m_n == 1) ? bus.io_in[1] : bus.io_in[i]};
        m_bits++;
      end
      if (m_bits == 8) begin
        m_bits = 0;
        m_bytes.push_back(m_cur);
        exp_rcvd = m_bytes.size();
        if (exp_rcvd % 4 == 0 || exp_rcvd == m_cnt) begin
          exp_wen  = 1;
          exp_data = '0;
          for (int k = (exp_rcvd - 1) / 4 * 4; k < exp_rcvd; k++)
            exp_data |= 32'(m_bytes[k]) << (8 * (k % 4));
          if (bus.rx_full) exp_drop = 1;
        end
        if (exp_rcvd == m_cnt) begin m_act = 0; m_dn = 1; exp_done = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_wen", 32'(bus.rx_wen), 32'(exp_wen));
      chk("rx_data_fifo", bus.rx_data_fifo, exp_data);
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("busy", 32'(bus.busy), 32'(m_act));
      chk("bytes_rcvd", 32'(bus.bytes_rcvd), 32'(exp_rcvd));
      chk("drop_err", 32'(bus.drop_err), 32'(exp_drop));
    end
  end

  // raw capture of DUT writes for the literal checks
  logic [31:0] wq[$];
  int dcnt = 0, coinc = 0;
  always @(negedge clk) begin
    if (bus.rx_wen) wq.push_back(bus.rx_data_fifo);
    if (bus.done) dcnt++;
    if (bus.done && bus.rx_wen) coinc++;
  end

  logic [7:0] txb[0:15];

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic clr(); wq.delete(); dcnt = 0; coinc = 0; endtask

  task automatic start_xfer(input int cnt, input logic [1:0] mode);
    bus.start = 1'b1; bus.byte_count = cnt[15:0]; bus.lane_mode = mode;
    tick();
    bus.start = 1'b0; bus.byte_count = 16'($urandom);
  endtask

  task automatic send(input int first, input int nb, input logic [1:0] mode, input int maxgap);
    int n;
    n = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
    for (int k = first; k < first + nb; k++) begin
      logic [7:0] v;
      v = txb[k];
      for (int j = 0; j < 8 / n; j++) begin
        logic [3:0] io;
        io = 4'($urandom);
        case (n)
          1: io[1]   = v[7];
          2: io[1:0] = v[7:6];
          default: io = v[7:4];
        endcase
        v = v << n;
        bus.sample_en = 1'b1; bus.io_in = io;
        tick();
        bus.sample_en = 1'b0; bus.io_in = 4'($urandom);
        repeat ($urandom_range(maxgap, 0)) tick();
      end
    end
  endtask

  task automatic pulse_abort(input logic with_sample);
    bus.abort = 1'b1; bus.sample_en = with_sample;
    tick();
    bus.abort = 1'b0; bus.sample_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.abort = 0; bus.byte_count = '0; bus.lane_mode = '0;
    bus.sample_en = 0; bus.io_in = '0; bus.rx_full = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rcvd", 32'(bus.bytes_rcvd), 0);
    chk("rst_data", bus.rx_data_fifo, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // quad DEADBEEF
    clr();
    txb[0] = 8'hDE; txb[1] = 8'hAD; txb[2] = 8'hBE; txb[3] = 8'hEF;
    start_xfer(4, 2'b10); send(0, 4, 2'b10, 0); repeat (3) tick();
    chk("t1_nwords", wq.size(), 1);
    chk("t1_word", (wq.size() > 0) ? wq[0] : 32'hx, 32'hEFBEADDE);
    chk("t1_done", dcnt, 1);
    chk("t1_coinc", coinc, 1);
    chk("t1_rcvd", 32'(bus.bytes_rcvd), 4);

    // single, 5 bytes
    clr();
    for (int i = 0; i < 5; i++) txb[i] = 8'(i + 1);
    start_xfer(5, 2'b00); send(0, 5, 2'b00, 1); repeat (3) tick();
    chk("t2_nwords", wq.size(), 2);
    chk("t2_word0", (wq.size() > 0) ? wq[0] : 32'hx, 32'h04030201);
    chk("t2_word1", (wq.size() > 1) ? wq[1] : 32'hx, 32'h00000005);
    chk("t2_done", dcnt, 1);

    // dual with gaps
    clr();
    txb[0] = 8'hA5; txb[1] = 8'h3C;
    start_xfer(2, 2'b01); send(0, 2, 2'b01, 3); repeat (3) tick();
    chk("t3_nwords", wq.size(), 1);
    chk("t3_word", (wq.size() > 0) ? wq[0] : 32'hx, 32'h00003CA5);

    // zero count, then start while busy
    clr();
    start_xfer(0, 2'b10); repeat (3) tick();
    chk("t4_done", dcnt, 1);
    chk("t4_nwords", wq.size(), 0);
    chk("t4_rcvd", 32'(bus.bytes_rcvd), 0);
    clr();
    txb[0] = 8'h12; txb[1] = 8'h34; txb[2] = 8'h56; txb[3] = 8'h78;
    start_xfer(4, 2'b10); send(0, 2, 2'b10, 0);
    start_xfer(1, 2'b00); send(2, 2, 2'b10, 0); repeat (3) tick();
    chk("t4b_word", (wq.size() > 0) ? wq[0] : 32'hx, 32'h78563412);
    chk("t4b_rcvd", 32'(bus.bytes_rcvd), 4);

    // abort after 5 of 8 bytes
    clr();
    for (int i = 0; i < 8; i++) txb[i] = 8'($urandom);
    start_xfer(8, 2'b10); send(0, 5, 2'b10, 0); pulse_abort(1'b1);
    chk("t5_busy", 32'(bus.busy), 0);
    repeat (3) tick();
    chk("t5_nwords", wq.size(), 1);
    chk("t5_done", dcnt, 0);
    chk("t5_rcvd", 32'(bus.bytes_rcvd), 5);
    clr();
    txb[0] = 8'hDE; txb[1] = 8'hAD; txb[2] = 8'hBE; txb[3] = 8'hEF;
    start_xfer(4, 2'b10); send(0, 4, 2'b10, 0); repeat (3) tick();
    chk("t5b_word", (wq.size() > 0) ? wq[0] : 32'hx, 32'hEFBEADDE);

    // FIFO full -> sticky drop_err, cleared by next start
    bus.rx_full = 1'b1;
    start_xfer(4, 2'b10); send(0, 4, 2'b10, 0);
    bus.rx_full = 1'b0;
    repeat (4) tick();
    chk("t6_drop", 32'(bus.drop_err), 1);
    start_xfer(1, 2'b00);
    chk("t6_drop_clr", 32'(bus.drop_err), 0);
    send(0, 1, 2'b00, 0); repeat (2) tick();

    // reset mid-transfer
    start_xfer(8, 2'b10); send(0, 2, 2'b10, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t7_busy", 32'(bus.busy), 0);
    chk("t7_rcvd", 32'(bus.bytes_rcvd), 0);
    chk("t7_wen", 32'(bus.rx_wen), 0);
    tick();

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      int cnt;
      logic [1:0] mode;
      mode = 2'($urandom);
      cnt  = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(9, 1));
      for (int i = 0; i < 16; i++) txb[i] = 8'($urandom);
      bus.rx_full = 1'($urandom);
      start_xfer(cnt, mode);
      if (cnt > 1 && $urandom_range(3, 0) == 0) begin
        send(0, int'($urandom_range(cnt - 1, 0)), mode, 2);
        pulse_abort(1'($urandom));
      end else if (cnt > 0) begin
        send(0, cnt, mode, 2);
      end
      repeat ($urandom_range(3, 1)) begin
        bus.sample_en = 1'($urandom); bus.io_in = 4'($urandom); bus.abort = 1'($urandom);
        tick();
        bus.sample_en = 1'b0; bus.abort = 1'b0;
      end
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qspi_rx_packer.md
Name: qspi_rx_packer

Overview:
Receive-side deserializer between the QSPI pad sampling logic and the RX FIFO. It samples the IO lines on each sampling strobe in single, dual or quad mode and assembles bytes MSB-first. It packs bytes little-endian into 32-bit words and issues one-cycle write pulses (rx_wen / rx_data_fifo) to the RX FIFO. It tracks the programmed byte count, flushes a zero-filled partial last word, and reports completion, abort and dropped-write status to the QSPI FSM and CSRs.

Parameters:
DATA_WIDTH, 32, word width to FIFO; fixed at 32 (4 bytes/word)
CNT_WIDTH, 16, width of byte-count and received-count fields

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  pulse; begins a receive of byte_count bytes; ignored while busy
abort  input  1  pulse; terminates the transfer, discards the partial word
byte_count  input  CNT_WIDTH  bytes to receive, sampled on start
lane_mode  input  2  00 single (io_in[1]), 01 dual (io_in[1:0]), 10 quad (io_in[3:0]), 11 reserved = single; sampled on start
sample_en  input  1  one-cycle strobe: io_in valid this cycle
io_in  input  4  synchronized QSPI IO lines
rx_full  input  1  RX FIFO full status
rx_wen  output  1  write pulse to RX FIFO
rx_data_fifo  output  DATA_WIDTH  packed word, valid when rx_wen=1
busy  output  1  high in SHIFT state
done  output  1  one-cycle pulse at normal completion
bytes_rcvd  output  CNT_WIDTH  bytes assembled in current/last transfer
drop_err  output  1  sticky: rx_wen issued while rx_full=1; cleared on start

Behaviour:
- Reset: state=IDLE; rx_wen=0, rx_data_fifo=0, busy=0, done=0, bytes_rcvd=0, drop_err=0; all internal counters and shift registers cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: on start with byte_count!=0 -> SHIFT; latch lane_mode and byte_count; clear bytes_rcvd, drop_err, bit_cnt, byte_idx and word register. On start with byte_count==0 -> DONE directly, with no rx_wen.
- SHIFT: each sample_en shifts n bits (n=1/2/4) into byte_sr: byte_sr <= {byte_sr[7-n:0], bits}. Dual bits = {io_in[1],io_in[0]}; quad bits = io_in[3:0] (io_in[3] MSB). bit_cnt advances by n.
- Byte complete (bit_cnt reaches 8): the byte goes into word lane byte_idx (first byte -> [7:0]); bytes_rcvd increments; bytes_left decrements; byte_idx increments mod 4.
- Word issue: if byte_idx==3 or this is the last byte, then on the same clock edge rx_wen<=1 and rx_data_fifo<=assembled word with unfilled upper bytes zero. rx_wen is therefore high the cycle after the completing sample_en, for exactly one cycle. The word register then clears.
- Last byte -> DONE. DONE lasts one cycle: done=1, then -> IDLE. For a nonzero count, done coincides with the final rx_wen.
- rx_data_fifo holds its value between pulses.
- sample_en in IDLE/DONE is ignored. start in SHIFT/DONE is ignored.
- abort in SHIFT: -> IDLE next cycle; partial word discarded; no rx_wen or done from the aborting cycle onward; bytes_rcvd holds. abort has priority over a simultaneous sample_en. abort in IDLE has no effect.
- drop_err: set when rx_wen is asserted while rx_full=1, checked at the issuing edge. The packer never stalls; the FIFO also flags the overrun.
- bytes_left counts down with wrap-free CNT_WIDTH arithmetic; max 2^CNT_WIDTH-1 bytes.
- rst mid-transfer: everything returns to reset values on the next edge; no rx_wen.

Test Plan:
- Quad, byte_count=4, nibbles D,E,A,D,B,E,E,F on 8 sample_en -> single rx_wen, rx_data_fifo=0xEFBEADDE, done on the same cycle, bytes_rcvd=4.
- Single, byte_count=5, bytes 0x01..0x05 MSB-first on io_in[1] (40 strobes) -> rx_wen with 0x04030201 after strobe 32, then rx_wen with 0x00000005 plus done after strobe 40.
- Dual, byte_count=2, bytes 0xA5,0x3C (8 strobes, gaps of 0-3 idle cycles between strobes) -> one rx_wen with 0x00003CA5; busy high from start until done.
- byte_count=0 start -> done pulse 1 cycle later, no rx_wen, bytes_rcvd=0; a start issued while busy has no effect.
- Quad, byte_count=8, abort after 5 bytes -> exactly one rx_wen (first word), no done, bytes_rcvd=5, IDLE next cycle; a new start then works normally.
- rx_full=1 held during a 4-byte quad transfer -> rx_wen still issued, drop_err=1 and sticky until the next start; rst asserted mid-SHIFT -> all outputs 0 on the next cycle.
